// File: rtl/seg7_stream_decoder.sv
// rtl/seg7_stream_decoder.sv - seven-segment glyph sampler, debouncer and hex decoder
// with a first-word-fall-through digit FIFO read over a valid/ready handshake.
module seg7_stream_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter int FIFO_DEPTH    = 4,
    parameter int CNT_W         = 8
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          en,
    input  logic [6:0]                    seg_in,
    input  logic                          dp_in,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [3:0]                    out_digit,
    output logic                          out_dp,
    output logic                          out_illegal,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow,
    output logic [CNT_W-1:0]              err_count
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int LW = AW + 1;
    localparam int SW = $clog2(STABLE_CYCLES + 1);
    localparam logic [SW-1:0] STABLE_MAX = SW'(STABLE_CYCLES);
    localparam logic [LW-1:0] FULL_LEVEL = LW'(FIFO_DEPTH);

    logic [7:0]    s1, s2, cand, last;
    logic [SW-1:0] cnt, cnt_next;
    logic          load, accept, fire;
    logic          acc_q;
    logic [5:0]    acc_data;
    logic [4:0]    dec;

    logic [5:0]    mem [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr, rd_ptr;
    logic [LW-1:0] level_next;
    logic          full, pop, do_push;

    // Returns {illegal, digit}; blank is never decoded because it is never pushed.
    function automatic logic [4:0] decode(input logic [6:0] seg);
        case (seg)
            7'h3F: decode = 5'h00;
            7'h06: decode = 5'h01;
            7'h5B: decode = 5'h02;
            7'h4F: decode = 5'h03;
            7'h66: decode = 5'h04;
            7'h6D: decode = 5'h05;
            7'h7D: decode = 5'h06;
            7'h07: decode = 5'h07;
            7'h7F: decode = 5'h08;
            7'h6F: decode = 5'h09;
            7'h77: decode = 5'h0A;
            7'h7C: decode = 5'h0B;
            7'h39: decode = 5'h0C;
            7'h5E: decode = 5'h0D;
            7'h79: decode = 5'h0E;
            7'h71: decode = 5'h0F;
            default: decode = 5'h10;
        endcase
    endfunction

    // cand always follows s2, so the glyph being accepted is s2 itself.
    always_comb begin
        load = (s2 != cand);
        cnt_next = cnt;
        if (!en)
            cnt_next = '0;
        else if (load)
            cnt_next = SW'(1);
        else if (cnt != STABLE_MAX)
            cnt_next = cnt + SW'(1);
        accept = en && (cnt_next == STABLE_MAX) && (load || (cnt != STABLE_MAX));
        fire   = accept && (s2 != last) && (s2[6:0] != 7'h00);
        dec    = decode(s2[6:0]);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            s1       <= 8'h00;
            s2       <= 8'h00;
            cand     <= 8'h00;
            last     <= 8'h00;
            cnt      <= '0;
            acc_q    <= 1'b0;
            acc_data <= 6'h00;
        end else begin
            s1    <= {dp_in, seg_in};
            s2    <= s1;
            cand  <= s2;
            cnt   <= cnt_next;
            acc_q <= fire;
            acc_data <= {dec[4], s2[7], dec[3:0]};
            if (accept)
                last <= s2;
        end
    end

    always_comb begin
        full       = (fifo_level == FULL_LEVEL);
        pop        = out_valid && out_ready;
        do_push    = acc_q && (!full || pop);
        level_next = fifo_level + LW'(do_push) - LW'(pop);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fifo_level <= '0;
            out_valid  <= 1'b0;
            overflow   <= 1'b0;
            err_count  <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++)
                mem[i] <= 6'h00;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= acc_data;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop)
                rd_ptr <= rd_ptr + AW'(1);
            if (acc_q && full && !pop)
                overflow <= 1'b1;
            if (acc_q && acc_data[5] && (err_count != {CNT_W{1'b1}}))
                err_count <= err_count + CNT_W'(1);
            fifo_level <= level_next;
            out_valid  <= (level_next != '0);
        end
    end

    always_comb begin
        out_digit   = out_valid ? mem[rd_ptr][3:0] : 4'h0;
        out_dp      = out_valid ? mem[rd_ptr][4]   : 1'b0;
        out_illegal = out_valid ? mem[rd_ptr][5]   : 1'b0;
    end
endmodule

// File: tb/tb_seg7_stream_decoder.sv
// tb/tb_seg7_stream_decoder.sv - scoreboard bench for seg7_stream_decoder
// with directed glyph sequences and hand-computed FIFO entries.
module tb_seg7_stream_decoder;
    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       en = 1'b1;
    logic [6:0] seg_in = 7'h00;
    logic       dp_in = 1'b0;
    logic       out_valid;
    logic       out_ready = 1'b0;
    logic [3:0] out_digit;
    logic       out_dp;
    logic       out_illegal;
    logic [2:0] fifo_level;
    logic       overflow;
    logic [7:0] err_count;

    int checks = 0;
    int failures = 0;
    logic [5:0] exp_q[$];

    seg7_stream_decoder dut (
        .clk(clk), .rst(rst), .en(en), .seg_in(seg_in), .dp_in(dp_in),
        .out_valid(out_valid), .out_ready(out_ready), .out_digit(out_digit),
        .out_dp(out_dp), .out_illegal(out_illegal), .fifo_level(fifo_level),
        .overflow(overflow), .err_count(err_count)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic hold(input logic [6:0] s, input logic d, input int n);
        seg_in = s;
        dp_in  = d;
        step(n);
    endtask

    task automatic do_reset();
        seg_in = 7'h00;
        dp_in  = 1'b0;
        rst    = 1'b1;
        step(1);
        rst    = 1'b0;
        exp_q.delete();
    endtask

    // Entries are {illegal, dp, digit}, compared at every handshake.
    initial begin
        logic [5:0] e;
        forever begin
            @(negedge clk);
            #1;
            if (!rst && out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    chk("unexpected_pop", {26'h0, out_illegal, out_dp, out_digit}, 32'h3F);
                end else begin
                    e = exp_q.pop_front();
                    chk("pop_entry", {26'h0, out_illegal, out_dp, out_digit}, {26'h0, e});
                end
            end
        end
    end

    initial begin
        step(2);
        do_reset();
        chk("rst_valid", out_valid, 0);
        chk("rst_digit", out_digit, 0);
        chk("rst_level", fifo_level, 0);
        chk("rst_overflow", overflow, 0);
        chk("rst_err", err_count, 0);

        // Latency and single push for a held glyph.
        out_ready = 1'b0;
        seg_in = 7'h3F;
        step(6);
        chk("lat_not_yet", out_valid, 0);
        step(1);
        chk("lat_valid", out_valid, 1);
        chk("lat_digit", out_digit, 4'h0);
        chk("lat_illegal", out_illegal, 0);
        chk("lat_level", fifo_level, 1);
        step(13);
        chk("no_second_push", fifo_level, 1);
        exp_q.push_back(6'h00);
        out_ready = 1'b1;
        step(2);
        chk("t1_drained", fifo_level, 0);
        chk("t1_q_empty", exp_q.size(), 0);

        // Repeat digit separated by blank, dp captured on the second.
        do_reset();
        out_ready = 1'b1;
        exp_q.push_back(6'h01);
        exp_q.push_back(6'h11);
        hold(7'h06, 1'b0, 10);
        hold(7'h00, 1'b0, 10);
        hold(7'h06, 1'b1, 10);
        step(4);
        chk("t2_q_empty", exp_q.size(), 0);
        chk("t2_level", fifo_level, 0);

        // Short glitch must not produce entries.
        do_reset();
        out_ready = 1'b1;
        exp_q.push_back(6'h03);
        hold(7'h4F, 1'b0, 10);
        hold(7'h5B, 1'b0, 2);
        hold(7'h4F, 1'b0, 10);
        step(4);
        chk("t3_q_empty", exp_q.size(), 0);
        chk("t3_valid", out_valid, 0);

        // Overflow: six glyphs into a four-entry FIFO.
        do_reset();
        out_ready = 1'b0;
        exp_q.push_back(6'h00);
        exp_q.push_back(6'h01);
        exp_q.push_back(6'h02);
        exp_q.push_back(6'h03);
        hold(7'h3F, 1'b0, 10);
        hold(7'h06, 1'b0, 10);
        hold(7'h5B, 1'b0, 10);
        hold(7'h4F, 1'b0, 10);
        chk("t4_no_ovf_yet", overflow, 0);
        hold(7'h66, 1'b0, 10);
        hold(7'h6D, 1'b0, 10);
        chk("t4_level_full", fifo_level, 4);
        chk("t4_overflow", overflow, 1);
        out_ready = 1'b1;
        step(8);
        chk("t4_q_empty", exp_q.size(), 0);
        chk("t4_level_empty", fifo_level, 0);
        chk("t4_ovf_sticky", overflow, 1);

        // Push into a full FIFO on the same cycle as a pop.
        do_reset();
        out_ready = 1'b0;
        for (int i = 0; i < 5; i++)
            exp_q.push_back(6'(i));
        hold(7'h3F, 1'b0, 10);
        hold(7'h06, 1'b0, 10);
        hold(7'h5B, 1'b0, 10);
        hold(7'h4F, 1'b0, 10);
        chk("t5_full", fifo_level, 4);
        seg_in = 7'h66;
        step(6);
        out_ready = 1'b1;
        step(1);
        out_ready = 1'b0;
        chk("t5_level_kept", fifo_level, 4);
        chk("t5_no_overflow", overflow, 0);
        out_ready = 1'b1;
        step(8);
        chk("t5_q_empty", exp_q.size(), 0);
        chk("t5_level_empty", fifo_level, 0);

        // Illegal glyph, then reset in the middle of activity.
        do_reset();
        out_ready = 1'b1;
        exp_q.push_back(6'h20);
        hold(7'h7E, 1'b0, 10);
        chk("t6_q_empty", exp_q.size(), 0);
        chk("t6_err_count", err_count, 1);
        out_ready = 1'b0;
        hold(7'h79, 1'b1, 10);
        chk("t6_level", fifo_level, 1);
        chk("t6_digit_E", out_digit, 4'hE);
        chk("t6_dp", out_dp, 1);
        seg_in = 7'h5B;
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        exp_q.delete();
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_level", fifo_level, 0);
        chk("mid_rst_err", err_count, 0);
        chk("mid_rst_ovf", overflow, 0);
        chk("mid_rst_outs", {out_illegal, out_dp, out_digit}, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
